// File: rtl/axis_16b_pkt_arbiter_pkg.sv
// Shared types and helpers for the 16-byte AXIS packet arbiter.
//   flit16_t    : one 16-byte beat {data, tuser, tid, last}
//   arb_state_t : arbiter FSM state encoding
//   rr_pick     : round-robin search over a request vector
package axis_16B_pkg;

    localparam int TUSER_SOP_BIT = 7;
    localparam int FLIT_BYTES    = 16;

    typedef struct packed {
        logic [FLIT_BYTES*8-1:0] data;
        logic [7:0]              tuser;
        logic [2:0]              tid;
        logic                    last;
    } flit16_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } arb_state_t;

    // First set bit of req searching upward from ptr+1, wrapping at n_src.
    // Returns ptr unchanged when req is empty.
    function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int         n_src);
        logic [2:0] pick;
        logic [2:0] idx;
        logic       found;
        pick  = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = (idx == 3'(n_src - 1)) ? 3'd0 : idx + 3'd1;
            if (k <= n_src && !found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_16b_pkt_arbiter_skid2.sv
// axis_skid2: 2-entry valid/ready register slice carrying flit16_t.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_flit    : upstream beat, in_ready = at least one free entry
//   out_valid/out_flit  : head entry, popped on out_valid & out_ready
// in_ready is derived only from the registered occupancy, so the upstream
// ready path never sees out_ready combinationally.
module axis_skid2
    import axis_16B_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    in_valid,
    input  flit16_t in_flit,
    output logic    in_ready,
    output logic    out_valid,
    output flit16_t out_flit,
    input  logic    out_ready
);

    flit16_t    r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    logic w_push;
    logic w_pop;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign out_flit  = r_mem[r_rd_ptr];
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_flit;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/axis_16b_pkt_arbiter.sv
// axis_16b_pkt_arbiter: packet-locked round-robin merge of N_SRC 16-byte
// AXIS sources into one 16-byte AXIS stream, source index stamped on tid.
//   clk_16B, rst          : clock, async active-high reset
//   cfg_src_en            : per-source grant enable (sampled in IDLE only)
//   s_axis_*              : N_SRC packed source ports
//   m_axis_*              : merged output, driven from a 2-entry skid buffer
//   grant_idx, busy       : current/last grant, 1 while a packet is locked
//   err_sop               : 1-cycle pulse when a beat's sop bit is misplaced
module axis_16b_pkt_arbiter
    import axis_16B_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int SID_W = 3
)
(
    input  logic                 clk_16B,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     cfg_src_en,
    input  logic [N_SRC*128-1:0] s_axis_tdata,
    input  logic [N_SRC*8-1:0]   s_axis_tuser,
    input  logic [N_SRC-1:0]     s_axis_tvalid,
    input  logic [N_SRC-1:0]     s_axis_tlast,
    output logic [N_SRC-1:0]     s_axis_tready,
    output logic [127:0]         m_axis_tdata,
    output logic [7:0]           m_axis_tuser,
    output logic [SID_W-1:0]     m_axis_tid,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic [2:0]           grant_idx,
    output logic                 busy,
    output logic                 err_sop
);

    arb_state_t r_state;
    logic [2:0] r_grant;
    logic [2:0] r_rr_ptr;
    logic       r_busy;
    logic       r_first;
    logic       r_err_sop;

    logic [7:0]       w_req;
    logic [N_SRC-1:0] w_gnt_oh;
    logic [127:0]     w_sel_data;
    logic [7:0]       w_sel_user;
    logic             w_sel_valid;
    logic             w_sel_last;
    logic             w_skid_rdy;
    logic             w_acc;
    logic             w_out_valid;
    flit16_t          w_in_flit;
    flit16_t          w_out_flit;

    // Request vector and granted-source mux in one pass over the sources.
    always_comb begin
        w_req       = '0;
        w_gnt_oh    = '0;
        w_sel_data  = '0;
        w_sel_user  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            w_req[i] = s_axis_tvalid[i] & cfg_src_en[i];
            if (r_grant == 3'(i)) begin
                w_gnt_oh[i] = 1'b1;
                w_sel_data  = s_axis_tdata[i*128 +: 128];
                w_sel_user  = s_axis_tuser[i*8 +: 8];
                w_sel_valid = s_axis_tvalid[i];
                w_sel_last  = s_axis_tlast[i];
            end
        end
    end

    assign s_axis_tready = (r_state == ST_PKT && w_skid_rdy) ? w_gnt_oh : '0;
    assign w_acc         = (r_state == ST_PKT) & w_skid_rdy & w_sel_valid;

    always_comb begin
        w_in_flit       = '0;
        w_in_flit.data  = w_sel_data;
        w_in_flit.tuser = w_sel_user;
        w_in_flit.tid   = r_grant;
        w_in_flit.last  = w_sel_last;
    end

    always_ff @(posedge clk_16B or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= 3'd0;
            r_rr_ptr  <= 3'(N_SRC - 1);
            r_busy    <= 1'b0;
            r_first   <= 1'b0;
            r_err_sop <= 1'b0;
        end else begin
            // sop must be set on exactly the first beat of a packet
            r_err_sop <= w_acc & (r_first ? ~w_sel_user[TUSER_SOP_BIT]
                                          :  w_sel_user[TUSER_SOP_BIT]);
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_grant <= rr_pick(w_req, r_rr_ptr, N_SRC);
                        r_state <= ST_PKT;
                        r_busy  <= 1'b1;
                        r_first <= 1'b1;
                    end
                end
                ST_PKT: begin
                    if (w_acc) begin
                        r_first <= 1'b0;
                        if (w_sel_last) begin
                            r_rr_ptr <= r_grant;
                            r_state  <= ST_IDLE;
                            r_busy   <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    axis_skid2 u_skid (
        .clk       (clk_16B),
        .rst       (rst),
        .in_valid  (w_acc),
        .in_flit   (w_in_flit),
        .in_ready  (w_skid_rdy),
        .out_valid (w_out_valid),
        .out_flit  (w_out_flit),
        .out_ready (m_axis_tready)
    );

    assign m_axis_tvalid = w_out_valid;
    assign m_axis_tdata  = w_out_flit.data;
    assign m_axis_tuser  = w_out_flit.tuser;
    assign m_axis_tid    = SID_W'(w_out_flit.tid);
    assign m_axis_tlast  = w_out_flit.last;
    assign grant_idx     = r_grant;
    assign busy          = r_busy;
    assign err_sop       = r_err_sop;

endmodule
